// File: rtl/axis_master_pkt_gen.sv
// axis_master_pkt_gen: AXI4-Stream master emitting one incrementing-pattern packet per start,
// with a partial keep mask on the last beat and optional LFSR-throttled tvalid.
module axis_master_pkt_gen #(
    parameter bit         FLOW_SIM  = 1'b1,
    parameter int         MAX_BYTES = 512,
    parameter logic [5:0] LFSR_SEED = 6'b101101
) (
    input  logic        m_axis_aclk,
    input  logic        m_axis_areset,
    input  logic        start,
    input  logic [9:0]  pkt_bytes,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] pkt_count,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tstrb,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    localparam logic [10:0] MAX_B = 11'(MAX_BYTES);

    state_t      r_state, w_state;
    logic [9:0]  r_beats, w_beats, r_k, w_k;
    logic [3:0]  r_last_keep, w_last_keep, r_tkeep, w_tkeep;
    logic [31:0] r_seed, w_seed, r_tdata, w_tdata;
    logic [15:0] r_cnt, w_cnt;
    logic [5:0]  r_lfsr;
    logic        r_busy, w_busy, r_done, w_done, r_err, w_err;
    logic        r_tvalid, w_tvalid, r_tlast, w_tlast;
    logic        w_ok, w_gate, w_xfer, w_load, w_blast;
    logic [9:0]  w_in_beats, w_src_k, w_src_beats;
    logic [3:0]  w_in_keep, w_src_keep;
    logic [31:0] w_src_seed;

    assign w_ok        = (pkt_bytes != 10'd0) && ({1'b0, pkt_bytes} <= MAX_B);
    assign w_in_beats  = {2'b0, pkt_bytes[9:2]} + {9'b0, |pkt_bytes[1:0]};
    assign w_in_keep   = (pkt_bytes[1:0] == 2'b00) ? 4'hF : {1'b0, &pkt_bytes[1:0], pkt_bytes[1], 1'b1};
    // In IDLE the first beat is built straight from the command inputs so it appears the cycle after start.
    assign w_src_seed  = (r_state == IDLE) ? seed : r_seed;
    assign w_src_k     = (r_state == IDLE) ? 10'd0 : r_k;
    assign w_src_beats = (r_state == IDLE) ? w_in_beats : r_beats;
    assign w_src_keep  = (r_state == IDLE) ? w_in_keep : r_last_keep;
    assign w_blast     = (w_src_k == w_src_beats - 10'd1);
    assign w_gate      = !FLOW_SIM || r_lfsr[0];
    assign w_xfer      = r_tvalid && m_axis_tready;

    always_comb begin
        w_state     = r_state;
        w_beats     = r_beats;
        w_k         = r_k;
        w_last_keep = r_last_keep;
        w_seed      = r_seed;
        w_tdata     = r_tdata;
        w_tkeep     = r_tkeep;
        w_tvalid    = r_tvalid;
        w_tlast     = r_tlast;
        w_cnt       = r_cnt;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                if (w_ok) begin
                    w_state     = SEND;
                    w_busy      = 1'b1;
                    w_beats     = w_in_beats;
                    w_last_keep = w_in_keep;
                    w_seed      = seed;
                    w_k         = 10'd0;
                    w_load      = w_gate;
                end else begin
                    w_err = 1'b1;
                end
            end
            SEND: if (w_xfer && r_tlast) begin
                w_state  = DONE;
                w_tvalid = 1'b0;
                w_tlast  = 1'b0;
                w_done   = 1'b1;
                w_cnt    = r_cnt + 16'd1;
            end else if (!r_tvalid || w_xfer) begin
                w_tvalid = 1'b0;
                w_load   = w_gate && (r_k != r_beats);
            end
            DONE: begin
                w_state = IDLE;
                w_busy  = 1'b0;
            end
            default: w_state = IDLE;
        endcase
        if (w_load) begin
            w_tvalid = 1'b1;
            w_tdata  = w_src_seed + {22'b0, w_src_k};
            w_tkeep  = w_blast ? w_src_keep : 4'hF;
            w_tlast  = w_blast;
            w_k      = w_src_k + 10'd1;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            r_state     <= IDLE;
            r_beats     <= 10'd0;
            r_k         <= 10'd0;
            r_last_keep <= 4'h0;
            r_seed      <= 32'd0;
            r_tdata     <= 32'd0;
            r_tkeep     <= 4'h0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_cnt       <= 16'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_lfsr      <= LFSR_SEED;
        end else begin
            r_state     <= w_state;
            r_beats     <= w_beats;
            r_k         <= w_k;
            r_last_keep <= w_last_keep;
            r_seed      <= w_seed;
            r_tdata     <= w_tdata;
            r_tkeep     <= w_tkeep;
            r_tvalid    <= w_tvalid;
            r_tlast     <= w_tlast;
            r_cnt       <= w_cnt;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
            r_lfsr      <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign pkt_count     = r_cnt;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tstrb  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
endmodule
